// File: rtl/load_use_hazard_unit.sv
// Load-use / branch-operand stall controller: holds PC and IF/DE, bubbles EX for a counted number of cycles.
// Zero-latency combinational stall outputs; dmem_busy freezes the whole pipe and pauses the stall countdown.
module load_use_hazard_unit #(
    parameter int BR_EX_LOAD_STALL  = 2,
    parameter int BR_M1_LOAD_STALL  = 1,
    parameter int ALU_EX_LOAD_STALL = 1,
    parameter int CNT_W             = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             de_valid,
    input  logic [4:0]       de_rs1,
    input  logic [4:0]       de_rs2,
    input  logic [1:0]       de_use_rs,
    input  logic             de_is_branch,
    input  logic [4:0]       ex_rd,
    input  logic             ex_reg_write,
    input  logic             ex_is_load,
    input  logic [4:0]       m1_rd,
    input  logic             m1_reg_write,
    input  logic             m1_is_load,
    input  logic             dmem_busy,
    input  logic             flush_req,
    output logic             pc_hold,
    output logic             if_de_hold,
    output logic             de_ex_bubble,
    output logic             pipe_freeze,
    output logic             stalled,
    output logic [CNT_W-1:0] stall_cycles
);

    typedef enum logic {RUN, HOLD} state_t;

    localparam logic [1:0] BR_EX_N  = 2'(BR_EX_LOAD_STALL);
    localparam logic [1:0] BR_M1_N  = 2'(BR_M1_LOAD_STALL);
    localparam logic [1:0] ALU_EX_N = 2'(ALU_EX_LOAD_STALL);

    state_t           state;
    logic [1:0]       rem;
    logic [CNT_W-1:0] cnt;
    logic             ex_match;
    logic             m1_match;
    logic [1:0]       need;
    logic             active;

    // x0 is hardwired zero, so a write to it can never create a dependency
    assign ex_match = ex_reg_write && (ex_rd != 5'd0) &&
                      ((de_use_rs[0] && de_rs1 == ex_rd) || (de_use_rs[1] && de_rs2 == ex_rd));
    assign m1_match = m1_reg_write && (m1_rd != 5'd0) &&
                      ((de_use_rs[0] && de_rs1 == m1_rd) || (de_use_rs[1] && de_rs2 == m1_rd));

    always_comb begin
        need = 2'd0;
        if (de_valid) begin
            if (de_is_branch) begin
                if (ex_match && ex_is_load && BR_EX_N > need) need = BR_EX_N;
                if (m1_match && m1_is_load && BR_M1_N > need) need = BR_M1_N;
            end else begin
                if (ex_match && ex_is_load && ALU_EX_N > need) need = ALU_EX_N;
            end
        end
    end

    assign active = !rst && !dmem_busy && !flush_req && (state == HOLD || need != 2'd0);

    assign stalled      = active;
    assign pc_hold      = active;
    assign if_de_hold   = active;
    assign de_ex_bubble = active;
    assign pipe_freeze  = !rst && dmem_busy;
    assign stall_cycles = rst ? '0 : cnt;

    // A frozen cycle leaves state, rem and the counter untouched, so freezes never eat stall cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            rem   <= 2'd0;
            cnt   <= '0;
        end else if (!dmem_busy) begin
            if (active && cnt != '1)
                cnt <= cnt + 1'b1;
            if (flush_req) begin
                state <= RUN;
                rem   <= 2'd0;
            end else if (state == RUN) begin
                if (need != 2'd0) begin
                    rem   <= need - 2'd1;
                    state <= (need > 2'd1) ? HOLD : RUN;
                end
            end else begin
                rem <= rem - 2'd1;
                if (rem == 2'd1)
                    state <= RUN;
            end
        end
    end

endmodule

// File: tb/tb_load_use_hazard_unit.sv
// Directed table of per-cycle vectors for the hazard unit, plus a counter saturation sequence.
module tb_load_use_hazard_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       de_valid;
    logic [4:0] de_rs1, de_rs2;
    logic [1:0] de_use_rs;
    logic       de_is_branch;
    logic [4:0] ex_rd;
    logic       ex_reg_write, ex_is_load;
    logic [4:0] m1_rd;
    logic       m1_reg_write, m1_is_load;
    logic       dmem_busy, flush_req;
    logic       pc_hold, if_de_hold, de_ex_bubble, pipe_freeze, stalled;
    logic [3:0] stall_cycles;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    load_use_hazard_unit #(.CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .de_valid(de_valid), .de_rs1(de_rs1), .de_rs2(de_rs2), .de_use_rs(de_use_rs),
        .de_is_branch(de_is_branch),
        .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_is_load(ex_is_load),
        .m1_rd(m1_rd), .m1_reg_write(m1_reg_write), .m1_is_load(m1_is_load),
        .dmem_busy(dmem_busy), .flush_req(flush_req),
        .pc_hold(pc_hold), .if_de_hold(if_de_hold), .de_ex_bubble(de_ex_bubble),
        .pipe_freeze(pipe_freeze), .stalled(stalled), .stall_cycles(stall_cycles)
    );

    typedef struct {
        string      name;
        logic       rst, dv;
        logic [4:0] rs1, rs2;
        logic [1:0] use_rs;
        logic       br;
        logic [4:0] exrd;
        logic       exw, exld;
        logic [4:0] m1rd;
        logic       m1w, m1ld;
        logic       busy, flush;
        logic       e_st, e_fr;
        logic [3:0] e_cnt;
    } vec_t;

    vec_t vq[$];

    task automatic v(input string name, input logic r, input logic dv, input logic [4:0] rs1,
                     input logic [4:0] rs2, input logic [1:0] u, input logic br,
                     input logic [4:0] exrd, input logic exw, input logic exld,
                     input logic [4:0] m1rd, input logic m1w, input logic m1ld,
                     input logic busy, input logic flush,
                     input logic e_st, input logic e_fr, input logic [3:0] e_cnt);
        vec_t t;
        t.name = name; t.rst = r; t.dv = dv; t.rs1 = rs1; t.rs2 = rs2; t.use_rs = u; t.br = br;
        t.exrd = exrd; t.exw = exw; t.exld = exld; t.m1rd = m1rd; t.m1w = m1w; t.m1ld = m1ld;
        t.busy = busy; t.flush = flush; t.e_st = e_st; t.e_fr = e_fr; t.e_cnt = e_cnt;
        vq.push_back(t);
    endtask

    task automatic drive(input vec_t t);
        rst = t.rst; de_valid = t.dv; de_rs1 = t.rs1; de_rs2 = t.rs2; de_use_rs = t.use_rs;
        de_is_branch = t.br; ex_rd = t.exrd; ex_reg_write = t.exw; ex_is_load = t.exld;
        m1_rd = t.m1rd; m1_reg_write = t.m1w; m1_is_load = t.m1ld;
        dmem_busy = t.busy; flush_req = t.flush;
    endtask

    task automatic check(input string name, input logic e_st, input logic e_fr, input logic [3:0] e_cnt);
        checks++;
        if ({pc_hold, if_de_hold, de_ex_bubble, stalled} !== {4{e_st}}) begin
            errors++;
            $display("FAIL %s stall outs: got %b%b%b%b expected %b", name,
                     pc_hold, if_de_hold, de_ex_bubble, stalled, {4{e_st}});
        end
        checks++;
        if (pipe_freeze !== e_fr) begin
            errors++;
            $display("FAIL %s pipe_freeze: got %b expected %b", name, pipe_freeze, e_fr);
        end
        checks++;
        if (stall_cycles !== e_cnt) begin
            errors++;
            $display("FAIL %s stall_cycles: got %0d expected %0d", name, stall_cycles, e_cnt);
        end
    endtask

    initial begin
        vec_t idle;
        vec_t haz;
        //  name        rst dv rs1 rs2 use  br exrd w ld m1rd w ld busy fl  st fr cnt
        v("rst_haz",   1, 1,  5,  1, 2'b01, 0, 5, 1, 1, 0, 0, 0, 1, 0,  0, 0, 0);
        v("rst_idle",  1, 0,  0,  0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0);
        v("alu_ld",    0, 1,  5,  1, 2'b01, 0, 5, 1, 1, 0, 0, 0, 0, 0,  1, 0, 0);
        v("alu_ld_m1", 0, 1,  5,  1, 2'b01, 0, 0, 0, 0, 5, 1, 1, 0, 0,  0, 0, 1);
        v("idle1",     0, 0,  0,  0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1);
        v("br_ex_1",   0, 1,  5,  7, 2'b11, 1, 5, 1, 1, 0, 0, 0, 0, 0,  1, 0, 1);
        v("br_ex_2",   0, 1,  5,  7, 2'b11, 1, 0, 0, 0, 5, 1, 1, 0, 0,  1, 0, 2);
        v("br_ex_end", 0, 0,  0,  0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 3);
        v("br_m1",     0, 1,  7,  5, 2'b11, 1, 0, 0, 0, 5, 1, 1, 0, 0,  1, 0, 3);
        v("br_m1_end", 0, 0,  0,  0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 4);
        v("ld_x0",     0, 1,  0,  1, 2'b01, 0, 0, 1, 1, 0, 0, 0, 0, 0,  0, 0, 4);
        v("br_alu",    0, 1,  5,  7, 2'b11, 1, 5, 1, 0, 0, 0, 0, 0, 0,  0, 0, 4);
        v("dv0",       0, 0,  5,  7, 2'b11, 1, 5, 1, 1, 0, 0, 0, 0, 0,  0, 0, 4);
        v("use_off",   0, 1,  1,  5, 2'b01, 0, 5, 1, 1, 0, 0, 0, 0, 0,  0, 0, 4);
        v("no_wr",     0, 1,  5,  1, 2'b01, 0, 5, 0, 1, 0, 0, 0, 0, 0,  0, 0, 4);
        v("frz_st1",   0, 1,  5,  7, 2'b11, 1, 5, 1, 1, 0, 0, 0, 0, 0,  1, 0, 4);
        v("frz_a",     0, 0,  0,  0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 0,  0, 1, 5);
        v("frz_b",     0, 0,  0,  0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 1,  0, 1, 5);
        v("frz_c",     0, 0,  0,  0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 0,  0, 1, 5);
        v("frz_st2",   0, 0,  0,  0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 5);
        v("frz_end",   0, 0,  0,  0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 6);
        v("run_frz",   0, 1,  5,  1, 2'b01, 0, 5, 1, 1, 0, 0, 0, 1, 0,  0, 1, 6);
        v("run_unfrz", 0, 1,  5,  1, 2'b01, 0, 5, 1, 1, 0, 0, 0, 0, 0,  1, 0, 6);
        v("idle2",     0, 0,  0,  0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 7);
        v("fl_st1",    0, 1,  5,  7, 2'b11, 1, 5, 1, 1, 0, 0, 0, 0, 0,  1, 0, 7);
        v("fl_abort",  0, 1,  5,  7, 2'b11, 1, 0, 0, 0, 5, 1, 1, 0, 1,  0, 0, 8);
        v("fl_run",    0, 0,  0,  0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 8);
        v("fl_runhaz", 0, 1,  5,  1, 2'b01, 0, 5, 1, 1, 0, 0, 0, 0, 1,  0, 0, 8);
        v("rs_st1",    0, 1,  5,  7, 2'b11, 1, 5, 1, 1, 0, 0, 0, 0, 0,  1, 0, 8);
        v("rs_mid",    1, 1,  5,  7, 2'b11, 1, 0, 0, 0, 5, 1, 1, 1, 0,  0, 0, 0);
        v("rs_after",  0, 0,  0,  0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0);

        idle = vq[$];
        haz  = vq[2];
        drive(vq[0]);
        for (int i = 0; i < vq.size(); i++) begin
            @(posedge clk);
            #1;
            drive(vq[i]);
            @(negedge clk);
            check(vq[i].name, vq[i].e_st, vq[i].e_fr, vq[i].e_cnt);
        end

        // Back-to-back ALU load-use stalls, one per cycle, run the 4-bit counter to saturation
        for (int i = 0; i < 13; i++) begin
            @(posedge clk);
            #1;
            drive(haz);
        end
        @(negedge clk);
        check("sat_near", 1'b1, 1'b0, 4'd12);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            drive(haz);
        end
        @(negedge clk);
        check("sat_hold", 1'b1, 1'b0, 4'd15);
        @(posedge clk);
        #1;
        drive(idle);
        @(negedge clk);
        check("sat_idle", 1'b0, 1'b0, 4'd15);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
